// File: rtl/alu_pkg.sv
// Shared opcode encodings, status flag bit positions and helpers for the 16-bit ALU.
package alu_pkg;

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_ADC   = 5'd1;
  localparam logic [4:0] OP_SUB   = 5'd2;
  localparam logic [4:0] OP_SBB   = 5'd3;
  localparam logic [4:0] OP_INC   = 5'd4;
  localparam logic [4:0] OP_DEC   = 5'd5;
  localparam logic [4:0] OP_NEG   = 5'd6;
  localparam logic [4:0] OP_CMP   = 5'd7;
  localparam logic [4:0] OP_AND   = 5'd8;
  localparam logic [4:0] OP_OR    = 5'd9;
  localparam logic [4:0] OP_XOR   = 5'd10;
  localparam logic [4:0] OP_NAND  = 5'd11;
  localparam logic [4:0] OP_NOR   = 5'd12;
  localparam logic [4:0] OP_XNOR  = 5'd13;
  localparam logic [4:0] OP_NOT   = 5'd14;
  localparam logic [4:0] OP_PASSB = 5'd15;
  localparam logic [4:0] OP_SHL1  = 5'd16;
  localparam logic [4:0] OP_SHR1  = 5'd17;
  localparam logic [4:0] OP_SAR1  = 5'd18;
  localparam logic [4:0] OP_ROL1  = 5'd19;
  localparam logic [4:0] OP_ROR1  = 5'd20;
  localparam logic [4:0] OP_RCL1  = 5'd21;
  localparam logic [4:0] OP_RCR1  = 5'd22;
  localparam logic [4:0] OP_SHL   = 5'd23;
  localparam logic [4:0] OP_SHR   = 5'd24;
  localparam logic [4:0] OP_SAR   = 5'd25;
  localparam logic [4:0] OP_MUL   = 5'd26;
  localparam logic [4:0] OP_SWAPB = 5'd27;
  localparam logic [4:0] OP_PASSA = 5'd28;
  localparam logic [4:0] OP_CLR   = 5'd29;
  localparam logic [4:0] OP_SET   = 5'd30;
  localparam logic [4:0] OP_RSVD  = 5'd31;

  localparam int CF_BIT = 5;
  localparam int ZF_BIT = 4;
  localparam int NF_BIT = 3;
  localparam int VF_BIT = 2;
  localparam int PF_BIT = 1;
  localparam int AF_BIT = 0;

  function automatic logic parity_even(input logic [15:0] v);
    return ~^v;
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// Combinational shift/rotate unit: single-bit shifts, rotates, and variable shifts by amt_i.
// cout_o is the last bit shifted out; a variable shift by zero passes a_i with cout_o = 0.
module alu_shifter
  import alu_pkg::*;
(
  input  logic [15:0] a_i,
  input  logic [3:0]  amt_i,
  input  logic [4:0]  op_i,
  input  logic        cin_i,
  output logic [15:0] res_o,
  output logic        cout_o
);

  // One guard bit on each variable shift catches the last bit shifted out.
  logic [16:0] shl_w;
  logic [16:0] shr_w;
  logic [16:0] sar_w;

  assign shl_w = {1'b0, a_i} << amt_i;
  assign shr_w = {a_i, 1'b0} >> amt_i;
  assign sar_w = $signed({a_i, 1'b0}) >>> amt_i;

  always_comb begin
    res_o  = a_i;
    cout_o = 1'b0;
    case (op_i)
      OP_SHL1: begin res_o = {a_i[14:0], 1'b0};   cout_o = a_i[15]; end
      OP_SHR1: begin res_o = {1'b0, a_i[15:1]};   cout_o = a_i[0];  end
      OP_SAR1: begin res_o = {a_i[15], a_i[15:1]}; cout_o = a_i[0]; end
      OP_ROL1: begin res_o = {a_i[14:0], a_i[15]}; cout_o = a_i[15]; end
      OP_ROR1: begin res_o = {a_i[0], a_i[15:1]}; cout_o = a_i[0];  end
      OP_RCL1: begin res_o = {a_i[14:0], cin_i};  cout_o = a_i[15]; end
      OP_RCR1: begin res_o = {cin_i, a_i[15:1]};  cout_o = a_i[0];  end
      OP_SHL:  begin res_o = shl_w[15:0];         cout_o = shl_w[16]; end
      OP_SHR:  begin res_o = shr_w[16:1];         cout_o = shr_w[0];  end
      OP_SAR:  begin res_o = sar_w[16:1];         cout_o = sar_w[0];  end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu.sv
// 16-bit registered ALU, 1-cycle latency, one op per clock, no handshake.
// Define ALU_MUL_EN to build the 8x8 multiplier on opcode 26; otherwise it acts as reserved.
module alu
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic [4:0]  F,
  input  logic        Cin,
  output logic [15:0] Result,
  output logic [5:0]  Status
);

  logic [15:0] result_q, result_d;
  logic [5:0]  status_q, status_d;

  logic [15:0] op_a, op_b;
  logic        c_in, is_sub;
  logic [16:0] sum_w, dif_w;
  logic [4:0]  nib_sum_w, nib_dif_w;
  logic [15:0] ar_res;
  logic        ar_cf, ar_vf, ar_af;
  logic [15:0] sh_res;
  logic        sh_cout;

  // One shared adder/subtractor; INC/DEC/NEG reuse it with substituted operands.
  always_comb begin
    op_a   = A;
    op_b   = B;
    c_in   = 1'b0;
    is_sub = 1'b0;
    case (F)
      OP_ADC: c_in = Cin;
      OP_INC: op_b = 16'd1;
      OP_SUB: is_sub = 1'b1;
      OP_SBB: begin is_sub = 1'b1; c_in = Cin; end
      OP_DEC: begin is_sub = 1'b1; op_b = 16'd1; end
      OP_NEG: begin is_sub = 1'b1; op_a = 16'd0; op_b = A; end
      OP_CMP: is_sub = 1'b1;
      default: ;
    endcase
  end

  assign sum_w     = {1'b0, op_a} + {1'b0, op_b} + {16'd0, c_in};
  assign dif_w     = {1'b0, op_a} - {1'b0, op_b} - {16'd0, c_in};
  assign nib_sum_w = {1'b0, op_a[3:0]} + {1'b0, op_b[3:0]} + {4'd0, c_in};
  assign nib_dif_w = {1'b0, op_a[3:0]} - {1'b0, op_b[3:0]} - {4'd0, c_in};

  assign ar_res = is_sub ? dif_w[15:0] : sum_w[15:0];
  assign ar_cf  = is_sub ? dif_w[16]   : sum_w[16];
  assign ar_af  = is_sub ? nib_dif_w[4] : nib_sum_w[4];
  assign ar_vf  = is_sub ? ((op_a[15] != op_b[15]) && (ar_res[15] != op_a[15]))
                         : ((op_a[15] == op_b[15]) && (ar_res[15] != op_a[15]));

  alu_shifter u_shifter (
    .a_i    (A),
    .amt_i  (B[3:0]),
    .op_i   (F),
    .cin_i  (Cin),
    .res_o  (sh_res),
    .cout_o (sh_cout)
  );

  always_comb begin
    logic [15:0] zsrc;
    logic        cf, vf, af, flags_on, use_diff;
    result_d = 16'd0;
    cf       = 1'b0;
    vf       = 1'b0;
    af       = 1'b0;
    flags_on = 1'b1;
    use_diff = 1'b0;
    case (F)
      OP_ADD, OP_ADC, OP_INC, OP_SUB, OP_SBB, OP_DEC, OP_NEG: begin
        result_d = ar_res;
        cf = ar_cf; vf = ar_vf; af = ar_af;
      end
      OP_CMP: begin
        result_d = A;
        cf = ar_cf; vf = ar_vf; af = ar_af;
        use_diff = 1'b1;
      end
      OP_AND:   result_d = A & B;
      OP_OR:    result_d = A | B;
      OP_XOR:   result_d = A ^ B;
      OP_NAND:  result_d = ~(A & B);
      OP_NOR:   result_d = ~(A | B);
      OP_XNOR:  result_d = ~(A ^ B);
      OP_NOT:   result_d = ~A;
      OP_PASSB: result_d = B;
      OP_SHL1, OP_SHR1, OP_SAR1, OP_ROL1, OP_ROR1, OP_RCL1, OP_RCR1,
      OP_SHL, OP_SHR, OP_SAR: begin
        result_d = sh_res;
        cf = sh_cout;
      end
`ifdef ALU_MUL_EN
      OP_MUL:   result_d = {8'd0, A[7:0]} * {8'd0, B[7:0]};
`endif
      OP_SWAPB: result_d = {A[7:0], A[15:8]};
      OP_PASSA: result_d = A;
      OP_CLR:   result_d = 16'h0000;
      OP_SET:   result_d = 16'hFFFF;
      default:  flags_on = 1'b0;
    endcase

    zsrc = use_diff ? ar_res : result_d;
    status_d = 6'd0;
    if (flags_on) begin
      status_d[CF_BIT] = cf;
      status_d[ZF_BIT] = (zsrc == 16'd0);
      status_d[NF_BIT] = zsrc[15];
      status_d[VF_BIT] = vf;
      status_d[PF_BIT] = parity_even(zsrc);
      status_d[AF_BIT] = af;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= 16'd0;
      status_q <= 6'd0;
    end else begin
      result_q <= result_d;
      status_q <= status_d;
    end
  end

  assign Result = result_q;
  assign Status = status_q;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the registered 16-bit ALU; flags ordered {CF,ZF,NF,VF,PF,AF}.
module tb_alu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] A = 16'd0;
  logic [15:0] B = 16'd0;
  logic [4:0]  F = 5'd0;
  logic        Cin = 1'b0;
  logic [15:0] Result;
  logic [5:0]  Status;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [4:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] res;
    logic [5:0]  st;
  } vec_t;

  alu dut (
    .clk    (clk),
    .rst    (rst),
    .A      (A),
    .B      (B),
    .F      (F),
    .Cin    (Cin),
    .Result (Result),
    .Status (Status)
  );

  always #5 clk = ~clk;

  task automatic apply(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic c);
    F = op; A = a; B = b; Cin = c;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    apply(OP_ADD, 16'h1234, 16'h1111, 1'b0);
    n_cmp++;
    if (Result !== 16'h0000) begin
      n_bad++; $display("FAIL reset_result got=%h want=0000", Result);
    end
    n_cmp++;
    if (Status !== 6'b000000) begin
      n_bad++; $display("FAIL reset_status got=%b want=000000", Status);
    end
    rst = 1'b0;
    apply(OP_ADD, 16'h1234, 16'h1111, 1'b0);
    n_cmp++;
    if (Result !== 16'h2345) begin
      n_bad++; $display("FAIL post_reset_result got=%h want=2345", Result);
    end
    n_cmp++;
    if (Status !== 6'b000010) begin
      n_bad++; $display("FAIL post_reset_status got=%b want=000010", Status);
    end
  endtask

  task automatic test_arith();
    vec_t q[$];
    q.push_back('{OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 6'b001101});
    q.push_back('{OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 6'b110011});
    q.push_back('{OP_ADC, 16'h0001, 16'h0001, 1'b1, 16'h0003, 6'b000010});
    q.push_back('{OP_INC, 16'h000F, 16'h1234, 1'b1, 16'h0010, 6'b000001});
    q.push_back('{OP_SUB, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 6'b101011});
    q.push_back('{OP_SUB, 16'h0005, 16'h0005, 1'b0, 16'h0000, 6'b010010});
    q.push_back('{OP_SBB, 16'h0010, 16'h0000, 1'b1, 16'h000F, 6'b000011});
    q.push_back('{OP_DEC, 16'h8000, 16'h0000, 1'b0, 16'h7FFF, 6'b000101});
    q.push_back('{OP_NEG, 16'h0001, 16'h0000, 1'b0, 16'hFFFF, 6'b101011});
    q.push_back('{OP_CMP, 16'h0003, 16'h0005, 1'b0, 16'h0003, 6'b101001});
    foreach (q[i]) begin
      apply(q[i].op, q[i].a, q[i].b, q[i].cin);
      n_cmp++;
      if (Result !== q[i].res) begin
        n_bad++; $display("FAIL arith[%0d] op=%0d result got=%h want=%h", i, q[i].op, Result, q[i].res);
      end
      n_cmp++;
      if (Status !== q[i].st) begin
        n_bad++; $display("FAIL arith[%0d] op=%0d status got=%b want=%b", i, q[i].op, Status, q[i].st);
      end
    end
  endtask

  task automatic test_logic();
    vec_t q[$];
    q.push_back('{OP_XOR,   16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 6'b001010});
    q.push_back('{OP_NAND,  16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 6'b010010});
    q.push_back('{OP_NOT,   16'h00FF, 16'h0000, 1'b0, 16'hFF00, 6'b001010});
    q.push_back('{OP_AND,   16'h0F0F, 16'h00FF, 1'b0, 16'h000F, 6'b000010});
    q.push_back('{OP_PASSB, 16'h0000, 16'h0001, 1'b0, 16'h0001, 6'b000000});
    foreach (q[i]) begin
      apply(q[i].op, q[i].a, q[i].b, q[i].cin);
      n_cmp++;
      if (Result !== q[i].res) begin
        n_bad++; $display("FAIL logic[%0d] op=%0d result got=%h want=%h", i, q[i].op, Result, q[i].res);
      end
      n_cmp++;
      if (Status !== q[i].st) begin
        n_bad++; $display("FAIL logic[%0d] op=%0d status got=%b want=%b", i, q[i].op, Status, q[i].st);
      end
    end
  endtask

  task automatic test_shift();
    vec_t q[$];
    q.push_back('{OP_SHL1, 16'h8001, 16'h0000, 1'b0, 16'h0002, 6'b100000});
    q.push_back('{OP_SAR1, 16'h8001, 16'h0000, 1'b0, 16'hC000, 6'b101010});
    q.push_back('{OP_ROL1, 16'h8000, 16'h0000, 1'b0, 16'h0001, 6'b100000});
    q.push_back('{OP_RCR1, 16'h0002, 16'h0000, 1'b1, 16'h8001, 6'b001010});
    q.push_back('{OP_SHR,  16'h1238, 16'h0004, 1'b0, 16'h0123, 6'b100010});
    q.push_back('{OP_SHL,  16'h8001, 16'h0000, 1'b1, 16'h8001, 6'b001010});
    q.push_back('{OP_SAR,  16'h8000, 16'h000F, 1'b0, 16'hFFFF, 6'b001010});
    foreach (q[i]) begin
      apply(q[i].op, q[i].a, q[i].b, q[i].cin);
      n_cmp++;
      if (Result !== q[i].res) begin
        n_bad++; $display("FAIL shift[%0d] op=%0d result got=%h want=%h", i, q[i].op, Result, q[i].res);
      end
      n_cmp++;
      if (Status !== q[i].st) begin
        n_bad++; $display("FAIL shift[%0d] op=%0d status got=%b want=%b", i, q[i].op, Status, q[i].st);
      end
    end
  endtask

  task automatic test_misc();
    vec_t q[$];
    q.push_back('{OP_SWAPB, 16'h1234, 16'h0000, 1'b0, 16'h3412, 6'b000000});
    q.push_back('{OP_CLR,   16'h1234, 16'h5678, 1'b1, 16'h0000, 6'b010010});
    q.push_back('{OP_SET,   16'h0000, 16'h0000, 1'b0, 16'hFFFF, 6'b001010});
    q.push_back('{OP_RSVD,  16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 6'b000000});
`ifdef ALU_MUL_EN
    q.push_back('{OP_MUL,   16'hAAFF, 16'h55FF, 1'b0, 16'hFE01, 6'b001010});
`else
    q.push_back('{OP_MUL,   16'hAAFF, 16'h55FF, 1'b0, 16'h0000, 6'b000000});
`endif
    foreach (q[i]) begin
      apply(q[i].op, q[i].a, q[i].b, q[i].cin);
      n_cmp++;
      if (Result !== q[i].res) begin
        n_bad++; $display("FAIL misc[%0d] op=%0d result got=%h want=%h", i, q[i].op, Result, q[i].res);
      end
      n_cmp++;
      if (Status !== q[i].st) begin
        n_bad++; $display("FAIL misc[%0d] op=%0d status got=%b want=%b", i, q[i].op, Status, q[i].st);
      end
    end
  endtask

  task automatic test_back_to_back();
    apply(OP_SET, 16'h0000, 16'h0000, 1'b0);
    n_cmp++;
    if (Result !== 16'hFFFF) begin
      n_bad++; $display("FAIL b2b_set got=%h want=ffff", Result);
    end
    apply(OP_PASSA, 16'h0001, 16'hFFFF, 1'b0);
    n_cmp++;
    if (Result !== 16'h0001 || Status !== 6'b000000) begin
      n_bad++; $display("FAIL b2b_passa got=%h/%b want=0001/000000", Result, Status);
    end
    // Reset mid-stream must discard the operation presented with it.
    rst = 1'b1;
    apply(OP_SET, 16'h0000, 16'h0000, 1'b0);
    n_cmp++;
    if (Result !== 16'h0000 || Status !== 6'b000000) begin
      n_bad++; $display("FAIL b2b_reset got=%h/%b want=0000/000000", Result, Status);
    end
    rst = 1'b0;
    apply(OP_XNOR, 16'h00FF, 16'h0F0F, 1'b0);
    n_cmp++;
    if (Result !== 16'hF00F || Status !== 6'b001010) begin
      n_bad++; $display("FAIL b2b_xnor got=%h/%b want=f00f/001010", Result, Status);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_logic();
    test_shift();
    test_misc();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
